// File: rtl/ceespu_gpu_pkg.sv
// Shared definitions for the GPU text-RAM controller:
// command codes, engine FSM encoding and default geometry.
package ceespu_gpu_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [1:0] CMD_CLEAR  = 2'b01;
  localparam logic [1:0] CMD_SCROLL = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    SCR_RD   = 3'd2,
    SCR_WR   = 3'd3,
    SCR_FILL = 3'd4,
    DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/ceespu_port_arb.sv
// Single RAM port mux, CPU over engine, plus the CPU
// read-valid path aligned to the RAM's one-cycle latency.
module ceespu_port_arb #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_char_i,
  input  logic [15:0]       cpu_colour_i,
  input  logic              eng_en_i,
  input  logic              eng_we_i,
  input  logic [ADDR_W-1:0] eng_addr_i,
  input  logic [7:0]        eng_char_i,
  input  logic [15:0]       eng_colour_i,
  input  logic [7:0]        ram_char_i,
  input  logic [15:0]       ram_colour_i,
  output logic              eng_gnt_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_char_o,
  output logic [15:0]       ram_colour_o,
  output logic              cpu_rvalid_o,
  output logic [7:0]        cpu_rchar_o,
  output logic [15:0]       cpu_rcolour_o
);

  logic rvalid_q, rvalid_d;

  assign eng_gnt_o = ~cpu_req_i;

  always_comb begin
    ram_en_o     = eng_en_i;
    ram_we_o     = eng_we_i;
    ram_addr_o   = eng_addr_i;
    ram_char_o   = eng_char_i;
    ram_colour_o = eng_colour_i;
    if (cpu_req_i) begin
      ram_en_o     = 1'b1;
      ram_we_o     = cpu_we_i;
      ram_addr_o   = cpu_addr_i;
      ram_char_o   = cpu_char_i;
      ram_colour_o = cpu_colour_i;
    end
  end

  assign rvalid_d = cpu_req_i & ~cpu_we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rvalid_q <= 1'b0;
    else       rvalid_q <= rvalid_d;
  end

  // RAM data is already registered; gate it so idle outputs stay 0
  assign cpu_rvalid_o  = rvalid_q;
  assign cpu_rchar_o   = rvalid_q ? ram_char_i   : 8'h00;
  assign cpu_rcolour_o = rvalid_q ? ram_colour_i : 16'h0000;

endmodule

// File: rtl/ceespu_console_ctrl.sv
// Text/colour RAM write-side controller: CPU cell access
// with CLEAR / SCROLL bulk engine stalled by CPU traffic.
module ceespu_console_ctrl
  import ceespu_gpu_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = 12
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rst,
  input  logic              I_cpu_req,
  input  logic              I_cpu_we,
  input  logic [ADDR_W-1:0] I_cpu_addr,
  input  logic [7:0]        I_cpu_char,
  input  logic [15:0]       I_cpu_colour,
  output logic              O_cpu_rvalid,
  output logic [7:0]        O_cpu_rchar,
  output logic [15:0]       O_cpu_rcolour,
  input  logic              I_cmd_valid,
  input  logic [1:0]        I_cmd,
  input  logic [7:0]        I_fill_char,
  input  logic [15:0]       I_fill_colour,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_ram_en,
  output logic              O_ram_we,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic [7:0]        O_ram_char,
  output logic [15:0]       O_ram_colour,
  input  logic [7:0]        I_ram_char,
  input  logic [15:0]       I_ram_colour
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] BOT_A  = ADDR_W'(COLS*(ROWS-1));
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]        fchar_q, fchar_d;
  logic [15:0]       fcol_q, fcol_d;
  logic [7:0]        hchar_q;
  logic [15:0]       hcol_q;
  logic              rdp_q, rdp_d;

  logic              gnt;
  logic              eng_en, eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [7:0]        eng_char;
  logic [15:0]       eng_col;

  assign cnt_inc = cnt_q + 1'b1;
  assign rdp_d   = (state_q == SCR_RD) & gnt;

  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fchar_q <= '0;
      fcol_q  <= '0;
      hchar_q <= '0;
      hcol_q  <= '0;
      rdp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fchar_q <= fchar_d;
      fcol_q  <= fcol_d;
      rdp_q   <= rdp_d;
      if (rdp_q) begin
        hchar_q <= I_ram_char;
        hcol_q  <= I_ram_colour;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fchar_d = fchar_q;
    fcol_d  = fcol_q;
    unique case (state_q)
      IDLE: begin
        if (I_cmd_valid &&
            (I_cmd == CMD_CLEAR || I_cmd == CMD_SCROLL)) begin
          fchar_d = I_fill_char;
          fcol_d  = I_fill_colour;
          cnt_d   = '0;
          state_d = (I_cmd == CMD_CLEAR) ? CLR : SCR_RD;
        end
      end
      CLR, SCR_FILL: begin
        if (gnt) begin
          if (cnt_q == LAST_A) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      SCR_RD: begin
        if (gnt) state_d = SCR_WR;
      end
      SCR_WR: begin
        if (gnt) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == BOT_A) ? SCR_FILL : SCR_RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    eng_en   = 1'b0;
    eng_we   = 1'b0;
    eng_addr = '0;
    eng_char = '0;
    eng_col  = '0;
    O_busy   = 1'b0;
    O_done   = 1'b0;
    unique case (state_q)
      CLR, SCR_FILL: begin
        eng_en   = 1'b1;
        eng_we   = 1'b1;
        eng_addr = cnt_q;
        eng_char = fchar_q;
        eng_col  = fcol_q;
        O_busy   = 1'b1;
      end
      SCR_RD: begin
        eng_en   = 1'b1;
        eng_addr = cnt_q + COLS_A;
        O_busy   = 1'b1;
      end
      SCR_WR: begin
        // Source data is live on the RAM bus right after the read
        eng_en   = 1'b1;
        eng_we   = 1'b1;
        eng_addr = cnt_q;
        eng_char = rdp_q ? I_ram_char : hchar_q;
        eng_col  = rdp_q ? I_ram_colour : hcol_q;
        O_busy   = 1'b1;
      end
      DONE: begin
        O_done = 1'b1;
      end
      default: begin
        O_busy = 1'b0;
      end
    endcase
  end

  ceespu_port_arb #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .clk_i        (I_sys_clk),
    .rst_i        (I_sys_rst),
    .cpu_req_i    (I_cpu_req),
    .cpu_we_i     (I_cpu_we),
    .cpu_addr_i   (I_cpu_addr),
    .cpu_char_i   (I_cpu_char),
    .cpu_colour_i (I_cpu_colour),
    .eng_en_i     (eng_en),
    .eng_we_i     (eng_we),
    .eng_addr_i   (eng_addr),
    .eng_char_i   (eng_char),
    .eng_colour_i (eng_col),
    .ram_char_i   (I_ram_char),
    .ram_colour_i (I_ram_colour),
    .eng_gnt_o    (gnt),
    .ram_en_o     (O_ram_en),
    .ram_we_o     (O_ram_we),
    .ram_addr_o   (O_ram_addr),
    .ram_char_o   (O_ram_char),
    .ram_colour_o (O_ram_colour),
    .cpu_rvalid_o (O_cpu_rvalid),
    .cpu_rchar_o  (O_cpu_rchar),
    .cpu_rcolour_o(O_cpu_rcolour)
  );

endmodule

// File: tb/tb_ceespu_console_ctrl.sv
// Bench for ceespu_console_ctrl: behavioural RAM, vector
// table for CPU access, command runs against a screen model.
`timescale 1ns/1ps
module tb_ceespu_console_ctrl;
  import ceespu_gpu_pkg::*;

  localparam int CELLS = 2400;
  localparam int BOT   = 2320;

  logic        clk = 1'b0;
  logic        rst;
  logic        I_cpu_req, I_cpu_we;
  logic [11:0] I_cpu_addr;
  logic [7:0]  I_cpu_char;
  logic [15:0] I_cpu_colour;
  logic        O_cpu_rvalid;
  logic [7:0]  O_cpu_rchar;
  logic [15:0] O_cpu_rcolour;
  logic        I_cmd_valid;
  logic [1:0]  I_cmd;
  logic [7:0]  I_fill_char;
  logic [15:0] I_fill_colour;
  logic        O_busy, O_done;
  logic        O_ram_en, O_ram_we;
  logic [11:0] O_ram_addr;
  logic [7:0]  O_ram_char;
  logic [15:0] O_ram_colour;
  logic [7:0]  I_ram_char;
  logic [15:0] I_ram_colour;

  always #5 clk = ~clk;

  ceespu_console_ctrl dut (
    .I_sys_clk    (clk),
    .I_sys_rst    (rst),
    .I_cpu_req    (I_cpu_req),
    .I_cpu_we     (I_cpu_we),
    .I_cpu_addr   (I_cpu_addr),
    .I_cpu_char   (I_cpu_char),
    .I_cpu_colour (I_cpu_colour),
    .O_cpu_rvalid (O_cpu_rvalid),
    .O_cpu_rchar  (O_cpu_rchar),
    .O_cpu_rcolour(O_cpu_rcolour),
    .I_cmd_valid  (I_cmd_valid),
    .I_cmd        (I_cmd),
    .I_fill_char  (I_fill_char),
    .I_fill_colour(I_fill_colour),
    .O_busy       (O_busy),
    .O_done       (O_done),
    .O_ram_en     (O_ram_en),
    .O_ram_we     (O_ram_we),
    .O_ram_addr   (O_ram_addr),
    .O_ram_char   (O_ram_char),
    .O_ram_colour (O_ram_colour),
    .I_ram_char   (I_ram_char),
    .I_ram_colour (I_ram_colour)
  );

  // behavioural RAM, {char, colour}, one-cycle read latency
  logic [23:0] mem [0:4095];
  logic [23:0] rd_q = '0;
  int ewr = 0;
  int erd = 0;
  assign I_ram_char   = rd_q[23:16];
  assign I_ram_colour = rd_q[15:0];

  always @(posedge clk) begin
    if (O_ram_en) begin
      if (O_ram_we) mem[O_ram_addr] <= {O_ram_char, O_ram_colour};
      else          rd_q <= mem[O_ram_addr];
    end
    if (O_ram_en && !I_cpu_req) begin
      if (O_ram_we) ewr++;
      else          erd++;
    end
  end

  logic [23:0] old [0:CELLS-1];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < CELLS; i++) begin
      old[i] = rnd ? 24'($urandom) : {8'(i), 16'(i)};
      I_cpu_req    = 1'b1;
      I_cpu_we     = 1'b1;
      I_cpu_addr   = 12'(i);
      I_cpu_char   = old[i][23:16];
      I_cpu_colour = old[i][15:0];
      cyc();
    end
    I_cpu_req = 1'b0;
    I_cpu_we  = 1'b0;
    cyc();
  endtask

  // expected screen from the pre-command image
  task automatic chk_mem(input string nm, input bit scroll,
                         input logic [23:0] fill);
    int bad;
    int first;
    logic [23:0] exp;
    bad = 0;
    first = -1;
    for (int i = 0; i < CELLS; i++) begin
      exp = (scroll && i < BOT) ? old[i+80] : fill;
      if (mem[i] !== exp) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_chk++;
    if (bad == 0) n_pass++;
    else $display("FAIL %s: %0d bad cells, first %0d got %0h expected %0h",
                  nm, bad, first, mem[first],
                  (scroll && first < BOT) ? old[first+80] : fill);
  endtask

  // modes: 0 plain, 1 extra cmds, 2 steal after read,
  // 3 random steals, 4 read cell 5 at cycle 3
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] fc,
                         input logic [15:0] fcl, input int mode,
                         output int done_k, output int ndone,
                         output int steals);
    logic rdpend, eng_rd, nreq;
    logic [23:0] exp_rd;
    done_k = -1;
    ndone  = 0;
    steals = 0;
    rdpend = 1'b0;
    exp_rd = '0;
    I_cmd_valid   = 1'b1;
    I_cmd         = c;
    I_fill_char   = fc;
    I_fill_colour = fcl;
    for (int k = 0; k < 9000; k++) begin
      @(negedge clk);
      chk("rvalid", 32'(O_cpu_rvalid), 32'(rdpend));
      if (rdpend)
        chk("rdata", {O_cpu_rchar, O_cpu_rcolour}, exp_rd);
      if (k == 0) chk("busy_pre", 32'(O_busy), 0);
      if (k == 1) chk("busy_run", 32'(O_busy), 1);
      if (O_done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          chk("busy_in_done", 32'(O_busy), 0);
        end
      end
      if (mode == 4 && k == 3) chk("steal_addr", 32'(O_ram_addr), 5);
      if (mode == 4 && k == 4) begin
        chk("stall_addr", 32'(O_ram_addr), 2);
        chk("read_cell5", {O_cpu_rchar, O_cpu_rcolour}, 24'h411C03);
      end
      if (done_k >= 0 && k == done_k + 2)
        chk("busy_after", 32'(O_busy), 0);
      eng_rd = O_ram_en && !O_ram_we && !I_cpu_req;
      rdpend = I_cpu_req && !I_cpu_we;
      exp_rd = mem[I_cpu_addr];
      if (done_k >= 0 && k >= done_k + 3) break;
      cyc();
      I_cmd_valid = 1'b0;
      if (mode == 1 && k + 1 == 10) begin
        I_cmd_valid   = 1'b1;
        I_cmd         = CMD_SCROLL;
        I_fill_char   = 8'h99;
        I_fill_colour = 16'h9999;
      end
      if (mode == 1 && done_k >= 0 && k == done_k) begin
        I_cmd_valid = 1'b1;
        I_cmd       = 2'b11;
      end
      case (mode)
        2:       nreq = eng_rd;
        3:       nreq = (k + 1 < 4000) && ($urandom_range(0, 3) == 0);
        4:       nreq = (k + 1 == 3);
        default: nreq = 1'b0;
      endcase
      I_cpu_req  = nreq;
      I_cpu_we   = 1'b0;
      I_cpu_addr = (mode == 4) ? 12'd5 : 12'($urandom_range(0, CELLS-1));
      if (nreq) steals++;
    end
    cyc();
    I_cmd_valid = 1'b0;
    I_cpu_req   = 1'b0;
  endtask

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  ch;
    logic [15:0] col;
    logic [7:0]  ech;
    logic [15:0] ecol;
  } vec_t;

  vec_t tv [8];
  int dk, nd, st, w0, r0;

  initial begin
    rst = 1'b1;
    I_cpu_req = 0; I_cpu_we = 0; I_cpu_addr = '0;
    I_cpu_char = '0; I_cpu_colour = '0;
    I_cmd_valid = 0; I_cmd = '0; I_fill_char = '0; I_fill_colour = '0;
    #3;
    chk("reset_outs", 32'(|{O_cpu_rvalid, O_cpu_rchar, O_cpu_rcolour,
        O_busy, O_done, O_ram_en, O_ram_we, O_ram_addr, O_ram_char,
        O_ram_colour}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc();

    tv[0] = '{1'b1, 12'd5,    8'h41, 16'h1C03, 8'h00, 16'h0000};
    tv[1] = '{1'b1, 12'd0,    8'h11, 16'hBEEF, 8'h00, 16'h0000};
    tv[2] = '{1'b1, 12'd2399, 8'h7E, 16'h0102, 8'h00, 16'h0000};
    tv[3] = '{1'b1, 12'd4095, 8'h55, 16'hAAAA, 8'h00, 16'h0000};
    tv[4] = '{1'b0, 12'd5,    8'h00, 16'h0000, 8'h41, 16'h1C03};
    tv[5] = '{1'b0, 12'd0,    8'h00, 16'h0000, 8'h11, 16'hBEEF};
    tv[6] = '{1'b0, 12'd2399, 8'h00, 16'h0000, 8'h7E, 16'h0102};
    tv[7] = '{1'b0, 12'd4095, 8'h00, 16'h0000, 8'h55, 16'hAAAA};
    for (int i = 0; i < 8; i++) begin
      I_cpu_req    = 1'b1;
      I_cpu_we     = tv[i].we;
      I_cpu_addr   = tv[i].addr;
      I_cpu_char   = tv[i].ch;
      I_cpu_colour = tv[i].col;
      @(negedge clk);
      chk("tv_en", 32'(O_ram_en), 1);
      chk("tv_we", 32'(O_ram_we), 32'(tv[i].we));
      chk("tv_addr", 32'(O_ram_addr), 32'(tv[i].addr));
      if (tv[i].we)
        chk("tv_wdata", {O_ram_char, O_ram_colour}, {tv[i].ch, tv[i].col});
      cyc();
      I_cpu_req = 1'b0;
      @(negedge clk);
      chk("tv_rvalid", 32'(O_cpu_rvalid), 32'(!tv[i].we));
      if (!tv[i].we)
        chk("tv_rdata", {O_cpu_rchar, O_cpu_rcolour}, {tv[i].ech, tv[i].ecol});
      cyc();
    end

    // CLEAR with a CPU read of cell 5 stealing cycle 3
    w0 = ewr; r0 = erd;
    run_cmd(CMD_CLEAR, 8'h2E, 16'h0707, 4, dk, nd, st);
    chk("clr_steal_done", dk, 2402);
    chk("clr_steal_wr", ewr - w0, CELLS);
    chk_mem("clr_steal_mem", 1'b0, 24'h2E0707);

    // CLEAR with a dropped SCROLL while busy and a dropped code 11
    w0 = ewr; r0 = erd;
    run_cmd(CMD_CLEAR, 8'h20, 16'h00FF, 1, dk, nd, st);
    chk("clr_done", dk, 2401);
    chk("clr_ndone", nd, 1);
    chk("clr_wr", ewr - w0, CELLS);
    chk("clr_rd", erd - r0, 0);
    chk_mem("clr_mem", 1'b0, 24'h2000FF);

    preload(1'b0);
    w0 = ewr; r0 = erd;
    run_cmd(CMD_SCROLL, 8'h00, 16'h0F00, 0, dk, nd, st);
    chk("scr_done", dk, 4721);
    chk("scr_wr", ewr - w0, CELLS);
    chk("scr_rd", erd - r0, BOT);
    chk("scr_cell0", 32'(mem[0][15:0]), 80);
    chk("scr_cell2319", 32'(mem[2319][15:0]), 2399);
    chk_mem("scr_mem", 1'b1, 24'h000F00);

    preload(1'b0);
    run_cmd(CMD_SCROLL, 8'h00, 16'h0F00, 2, dk, nd, st);
    chk("scr_steal_n", st, BOT);
    chk("scr_steal_done", dk, 4721 + st);
    chk_mem("scr_steal_mem", 1'b1, 24'h000F00);

    preload(1'b1);
    run_cmd(CMD_SCROLL, 8'hC4, 16'h3A5C, 3, dk, nd, st);
    chk("scr_rnd_done", dk, 4721 + st);
    chk("scr_rnd_ndone", nd, 1);
    chk_mem("scr_rnd_mem", 1'b1, 24'hC43A5C);

    // reset while the SCROLL is reading for dst 500
    preload(1'b0);
    I_cmd_valid   = 1'b1;
    I_cmd         = CMD_SCROLL;
    I_fill_char   = 8'h00;
    I_fill_colour = 16'h0000;
    cyc();
    I_cmd_valid = 1'b0;
    repeat (1000) cyc();
    @(negedge clk);
    chk("rst_pos_addr", 32'(O_ram_addr), 580);
    chk("rst_pos_rd", 32'(O_ram_en && !O_ram_we), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", 32'(|{O_cpu_rvalid, O_cpu_rchar, O_cpu_rcolour,
        O_busy, O_done, O_ram_en, O_ram_we, O_ram_addr, O_ram_char,
        O_ram_colour}), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(O_done), 0);
    end
    rst = 1'b0;
    chk("rst_copied499", mem[499], old[579]);
    chk("rst_left500", mem[500], old[500]);
    cyc();
    run_cmd(CMD_CLEAR, 8'h20, 16'h00FF, 0, dk, nd, st);
    chk("rst_clr_done", dk, 2401);
    chk_mem("rst_clr_mem", 1'b0, 24'h2000FF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
